// File: rtl/aggregator_if.sv
// Handshake and data bundle for the aggregator: 3x3 rule weights and singletons in,
// saturated weighted sums out.
interface aggregator_if;
   logic        in_valid;
   logic        reg_mode;
   logic [15:0] w00, w01, w02, w10, w11, w12, w20, w21, w22;
   logic [7:0]  g00, g01, g02, g10, g11, g12, g20, g21, g22;
   logic [15:0] S_w;
   logic [15:0] S_wg;
   logic        out_valid;

   modport master (
      output in_valid, reg_mode,
      output w00, w01, w02, w10, w11, w12, w20, w21, w22,
      output g00, g01, g02, g10, g11, g12, g20, g21, g22,
      input  S_w, S_wg, out_valid
   );

   modport slave (
      input  in_valid, reg_mode,
      input  w00, w01, w02, w10, w11, w12, w20, w21, w22,
      input  g00, g01, g02, g10, g11, g12, g20, g21, g22,
      output S_w, S_wg, out_valid
   );
endinterface

// File: rtl/aggregator.sv
// Single-cycle 3x3 rule aggregator: sums active weights and weight*singleton
// products in Q1.15 with per-product and output saturation.
module aggregator (
   input  logic          clk,
   input  logic          rst,
   aggregator_if.slave   bus
);

   logic [15:0] w [9];
   logic [7:0]  g [9];
   logic [8:0]  active;

   logic [31:0] gq_full;
   logic [14:0] gq;
   logic [31:0] p_full;
   logic [14:0] p;
   logic [19:0] acc_w;
   logic [19:0] acc_p;

   assign w = '{bus.w00, bus.w01, bus.w02, bus.w10, bus.w11, bus.w12, bus.w20, bus.w21, bus.w22};
   assign g = '{bus.g00, bus.g01, bus.g02, bus.g10, bus.g11, bus.g12, bus.g20, bus.g21, bus.g22};

   // Index is row*3+col, so corners sit at bits 0, 2, 6 and 8.
   assign active = bus.reg_mode ? 9'h1FF : 9'h145;

   always_comb begin
      gq_full = '0;
      gq      = '0;
      p_full  = '0;
      p       = '0;
      acc_w   = '0;
      acc_p   = '0;
      for (int unsigned i = 0; i < 9; i++) begin
         gq_full = (32'(g[i]) * 32'd32767 + 32'd50) / 32'd100;
         gq      = (gq_full > 32'd32767) ? 15'h7FFF : gq_full[14:0];
         p_full  = (32'(w[i]) * 32'(gq) + 32'd16384) >> 15;
         p       = (p_full > 32'd32767) ? 15'h7FFF : p_full[14:0];
         if (active[i]) begin
            acc_w = acc_w + 20'(w[i]);
            acc_p = acc_p + 20'(p);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.S_w       <= '0;
         bus.S_wg      <= '0;
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.S_w  <= (acc_w > 20'd32767) ? 16'd32767 : acc_w[15:0];
            bus.S_wg <= (acc_p > 20'd32767) ? 16'd32767 : acc_p[15:0];
         end
      end
   end

endmodule

// File: tb/tb_aggregator.sv
// Randomized and directed bench for aggregator, checked against an arithmetic
// reference model of the aggregation rules.
module tb_aggregator;

   logic clk = 1'b0;
   logic rst;
   logic in_valid;
   logic reg_mode;
   logic [15:0] w [9];
   logic [7:0]  g [9];

   int vectors     = 0;
   int miscompares = 0;

   aggregator_if bus ();

   assign bus.in_valid = in_valid;
   assign bus.reg_mode = reg_mode;
   assign bus.w00 = w[0];
   assign bus.w01 = w[1];
   assign bus.w02 = w[2];
   assign bus.w10 = w[3];
   assign bus.w11 = w[4];
   assign bus.w12 = w[5];
   assign bus.w20 = w[6];
   assign bus.w21 = w[7];
   assign bus.w22 = w[8];
   assign bus.g00 = g[0];
   assign bus.g01 = g[1];
   assign bus.g02 = g[2];
   assign bus.g10 = g[3];
   assign bus.g11 = g[4];
   assign bus.g12 = g[5];
   assign bus.g20 = g[6];
   assign bus.g21 = g[7];
   assign bus.g22 = g[8];

   aggregator dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic bit is_corner(input int i);
      return (i == 0) || (i == 2) || (i == 6) || (i == 8);
   endfunction

   function automatic void model(input logic m, output int sw, output int swg);
      longint sum_w = 0;
      longint sum_p = 0;
      longint gq;
      longint p;
      for (int i = 0; i < 9; i++) begin
         if (m || is_corner(i)) begin
            gq = (longint'(g[i]) * 32767 + 50) / 100;
            if (gq > 32767) gq = 32767;
            p = (longint'(w[i]) * gq + 16384) / 32768;
            if (p > 32767) p = 32767;
            sum_w += longint'(w[i]);
            sum_p += p;
         end
      end
      sw  = (sum_w > 32767) ? 32767 : int'(sum_w);
      swg = (sum_p > 32767) ? 32767 : int'(sum_p);
   endfunction

   task automatic randomize_inputs(input int wmax, input int gmax);
      reg_mode = 1'($urandom_range(0, 1));
      for (int i = 0; i < 9; i++) begin
         w[i] = 16'($urandom_range(0, wmax));
         g[i] = 8'($urandom_range(0, gmax));
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1;
      randomize_inputs(32767, 100);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         vectors++;
         if (bus.S_w !== 16'd0 || bus.S_wg !== 16'd0 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: S_w=%0d S_wg=%0d out_valid=%b, required 0 0 0",
                     bus.S_w, bus.S_wg, bus.out_valid);
         end
         @(negedge clk);
         randomize_inputs(32767, 100);
      end
      rst = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic test_directed();
      int exp_w [5] = '{20000, 32767, 32767, 32767, 0};
      int exp_g [5] = '{14000, 28500, 0, 32767, 0};
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         for (int i = 0; i < 9; i++) begin
            case (k)
               0, 1: begin w[i] = 16'((i + 1) * 1000); g[i] = 8'((i + 1) * 10); end
               2:    begin w[i] = 16'd32767; g[i] = 8'd0; end
               3:    begin w[i] = 16'd32767; g[i] = 8'd100; end
               default: begin
                  w[i] = is_corner(i) ? 16'd0 : ((i == 4) ? 16'd5000 : 16'd1000);
                  g[i] = 8'd50;
               end
            endcase
         end
         reg_mode = (k == 0 || k == 4) ? 1'b0 : 1'b1;
         in_valid = 1'b1;
         @(posedge clk); #1;
         vectors++;
         if (bus.out_valid !== 1'b1 || bus.S_w !== 16'(exp_w[k]) || bus.S_wg !== 16'(exp_g[k])) begin
            miscompares++;
            $display("FAIL directed[%0d]: S_w=%0d S_wg=%0d out_valid=%b, required %0d %0d 1",
                     k, bus.S_w, bus.S_wg, bus.out_valid, exp_w[k], exp_g[k]);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_random_gaps(input int n, input int wmax, input int gmax, input string tag);
      int hold_w = 32'(bus.S_w);
      int hold_g = 32'(bus.S_wg);
      int ew;
      int eg;
      bit valid_now;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         randomize_inputs(wmax, gmax);
         valid_now = ($urandom_range(0, 3) != 0);
         in_valid = valid_now;
         if (valid_now) begin
            model(reg_mode, ew, eg);
            hold_w = ew;
            hold_g = eg;
         end
         @(posedge clk); #1;
         vectors++;
         if (bus.out_valid !== valid_now || bus.S_w !== 16'(hold_w) || bus.S_wg !== 16'(hold_g)) begin
            miscompares++;
            $display("FAIL %s[%0d]: S_w=%0d S_wg=%0d out_valid=%b, required %0d %0d %b",
                     tag, c, bus.S_w, bus.S_wg, bus.out_valid, hold_w, hold_g, valid_now);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      int ew;
      int eg;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         randomize_inputs(32767, 100);
         reg_mode = 1'(c);
         in_valid = 1'b1;
         model(reg_mode, ew, eg);
         @(posedge clk); #1;
         vectors++;
         if (bus.out_valid !== 1'b1 || bus.S_w !== 16'(ew) || bus.S_wg !== 16'(eg)) begin
            miscompares++;
            $display("FAIL back_to_back[%0d]: S_w=%0d S_wg=%0d out_valid=%b, required %0d %0d 1",
                     c, bus.S_w, bus.S_wg, bus.out_valid, ew, eg);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_hold();
      int ew;
      int eg;
      @(negedge clk);
      randomize_inputs(32767, 100);
      in_valid = 1'b1;
      model(reg_mode, ew, eg);
      @(posedge clk);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         randomize_inputs(32767, 100);
         in_valid = 1'b0;
         @(posedge clk); #1;
         vectors++;
         if (bus.out_valid !== 1'b0 || bus.S_w !== 16'(ew) || bus.S_wg !== 16'(eg)) begin
            miscompares++;
            $display("FAIL hold[%0d]: S_w=%0d S_wg=%0d out_valid=%b, required %0d %0d 0",
                     c, bus.S_w, bus.S_wg, bus.out_valid, ew, eg);
         end
      end
   endtask

   task automatic test_reset_midstream();
      int ew;
      int eg;
      @(negedge clk);
      randomize_inputs(32767, 100);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      randomize_inputs(32767, 100);
      rst = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.S_w !== 16'd0 || bus.S_wg !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_mid: S_w=%0d S_wg=%0d out_valid=%b, required 0 0 0",
                  bus.S_w, bus.S_wg, bus.out_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.S_w !== 16'd0 || bus.S_wg !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_idle: S_w=%0d S_wg=%0d out_valid=%b, required 0 0 0",
                  bus.S_w, bus.S_wg, bus.out_valid);
      end
      @(negedge clk);
      randomize_inputs(32767, 100);
      in_valid = 1'b1;
      model(reg_mode, ew, eg);
      @(posedge clk); #1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.S_w !== 16'(ew) || bus.S_wg !== 16'(eg)) begin
         miscompares++;
         $display("FAIL first_after_reset: S_w=%0d S_wg=%0d out_valid=%b, required %0d %0d 1",
                  bus.S_w, bus.S_wg, bus.out_valid, ew, eg);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      reg_mode = 1'b0;
      for (int i = 0; i < 9; i++) begin
         w[i] = '0;
         g[i] = '0;
      end
      @(negedge clk);
      test_reset();
      test_directed();
      test_random_gaps(40, 32767, 100, "random");
      test_back_to_back();
      test_hold();
      test_reset_midstream();
      test_random_gaps(30, 65535, 255, "wide_inputs");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit, required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/aggregator.md
AGGREGATOR -- requirements
Module: aggregator

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high; ports are named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  qualifies the inputs sampled on the current clk edge.
REQ-005 reg_mode  input  1  rule mode: 0 = 4-rule (corners only), 1 = 9-rule (full 3x3).
REQ-006 w00..w22 (w00 w01 w02 w10 w11 w12 w20 w21 w22)  input  16 each  rule weights, unsigned Q1.15, nominal range 0..32767.
REQ-007 g00..g22 (same index set as the weights)  input  8 each  singleton outputs in percent, nominal range 0..100.
REQ-008 S_w  output  16  registered sum of active weights, Q1.15, saturated.
REQ-009 S_wg  output  16  registered sum of active weight*singleton products, Q1.15, saturated.
REQ-010 out_valid  output  1  high for one cycle when S_w and S_wg are updated.

Function
REQ-011 Active cells SHALL be:
- corners (00, 02, 20, 22) always;
- edges (01, 10, 12, 21) and centre (11) only when reg_mode=1.
- Inactive cells contribute 0 to both sums, whatever their w and g values.
REQ-012 Singleton conversion SHALL be gq = floor((g*32767 + 50)/100), computed at 32 bits or wider.
- The result is clamped to 32767, so g>100 gives 32767.
REQ-013 Each product SHALL be p = floor((w*gq + 16384) >> 15), using a 32-bit product and round-half-up.
- The result is clamped to 32767.
REQ-014 Accumulation SHALL use accumulators of at least 20 bits, so nine terms never wrap.
REQ-015 Final saturation:
- S_w = min(sum of active w, 32767);
- S_wg = min(sum of active p, 32767).
REQ-016 Weights are treated as unsigned 16-bit.
- Inputs above 32767 SHALL be accepted without error.
- Saturation applies only at the product and output stages.
REQ-017 Latency: on a rising clk edge with in_valid=1 and rst=0, the block SHALL register S_w and S_wg computed from the inputs sampled on that edge, and assert out_valid for the following cycle.
REQ-018 With in_valid=0, S_w and S_wg SHALL hold their previous values and out_valid SHALL be 0.
REQ-019 Back-to-back valid inputs SHALL produce back-to-back results at one result per cycle, with no stalls.
REQ-020 Changing reg_mode SHALL take effect on the next sampled in_valid cycle, with no other state carried between samples.

Reset
REQ-021 While rst=1 at a clk edge, S_w, S_wg and out_valid SHALL be 0, and in_valid SHALL be ignored.
REQ-022 Reset asserted mid-stream SHALL discard any result pending for the next cycle.
REQ-023 The first valid result after rst deasserts SHALL appear one cycle after the first in_valid=1 sample.

Verification
REQ-024 4-rule case:
- stimulus: mode=0; w00..w22 = 1000,2000,...,9000; g00..g22 = 10,20,...,90;
- required response: S_w=20000, S_wg=14000 (products 100, 900, 4900, 8100).
REQ-025 9-rule case:
- stimulus: same inputs as REQ-024 with mode=1;
- required response: S_w=32767 (45000 saturated), S_wg=28500.
REQ-026 S_w saturation case:
- stimulus: mode=1; all w=32767; all g=0;
- required response: S_w=32767, S_wg=0.
REQ-027 S_wg saturation case:
- stimulus: mode=1; all w=32767; all g=100 (gq=32767, each p=32766);
- required response: S_w=32767, S_wg=32767.
REQ-028 Gating case:
- stimulus: mode=0; corner w=0; non-corner w nonzero (1000 on edges, 5000 at centre); all g=50;
- required response: S_w=0, S_wg=0.
REQ-029 Random and control case:
- stimulus: at least 20 random vectors (mode 0/1, w 0..32767, g 0..100) with in_valid pulses, in_valid=0 gaps, and a rst pulse mid-stream;
- required response: each result matches the bit-accurate model one cycle later; outputs hold during gaps; outputs clear to 0 on reset.
